// File: rtl/ovl_fire_collector_pkg.sv
// Shared types for the OVL fire collector: status encoding, FIFO record layout, index width helper.
// OVL_FIRE_COLLECTOR_TS_EN adds a 32-bit push timestamp to each record.
package ovl_fire_pkg;

   localparam int unsigned IDX_MAX_W = 6;
   localparam int unsigned TS_WIDTH  = 32;

   typedef enum logic [1:0] {
      ST_OK     = 2'd0,
      ST_FAILED = 2'd1,
      ST_HALTED = 2'd2
   } status_e;

   typedef struct packed {
`ifdef OVL_FIRE_COLLECTOR_TS_EN
      logic [TS_WIDTH-1:0]  ts;
`endif
      logic [IDX_MAX_W-1:0] idx;
      logic                 multi;
   } fire_rec_t;

   // Index width kept at least 1 so a single-checker build still has a legal port.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ovl_fire_collector_if.sv
// Failure-record stream from the collector to the monitor (valid/ready).
// OVL_FIRE_COLLECTOR_TS_EN adds the per-record timestamp field.
interface ovl_fire_collector_if #(
   parameter int unsigned IDX_W = 3
);
   logic             valid;
   logic             ready;
   logic [IDX_W-1:0] idx;
   logic             multi;
`ifdef OVL_FIRE_COLLECTOR_TS_EN
   logic [31:0]      ts;

   modport master (output valid, idx, multi, ts, input ready);
   modport slave  (input valid, idx, multi, ts, output ready);
`else
   modport master (output valid, idx, multi, input ready);
   modport slave  (input valid, idx, multi, output ready);
`endif
endinterface

// File: rtl/ovl_fire_collector_fifo.sv
// Synchronous valid/ready FIFO for failure records; push while full succeeds only with a same-cycle pop.
module ovl_fire_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Power-of-two depth: pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fire bits: saturating violation count, first-failure latch, record FIFO, halt FSM.
// OVL_FIRE_COLLECTOR_TS_EN adds a free-running cycle counter stamped into each record (rec.ts).
module ovl_fire_collector
   import ovl_fire_pkg::*;
#(
   parameter int unsigned NUM_CHECKERS = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned MAX_FIRES    = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                clear,
   input  logic [NUM_CHECKERS-1:0]             fire,
   ovl_fire_collector_if.master                rec,
   output logic [CNT_WIDTH-1:0]                viol_count,
   output logic [idx_w(NUM_CHECKERS)-1:0]      first_idx,
   output status_e                             status,
   output logic                                overflow
);
   localparam int unsigned IDX_W = idx_w(NUM_CHECKERS);
   localparam int unsigned PC_W  = $clog2(NUM_CHECKERS + 1);
   localparam int unsigned SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
   localparam int unsigned REC_W = $bits(fire_rec_t);

   status_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]   count_q;
   logic [IDX_W-1:0]       first_q;
   logic                   ovf_q;
   logic [NUM_CHECKERS-1:0] fire_s;
   logic [PC_W-1:0]        pc;
   logic [IDX_W-1:0]       lo_idx;
   logic [SUM_W-1:0]       sum;
   logic [CNT_WIDTH-1:0]   cnt_sat;
   logic                   fire_any, fire_cycle, halt_hit, pop, full, empty;
   fire_rec_t              rec_in, rec_head;
   logic                   unused_ok;

   // Unknown bits count as fires, so X/Z never propagates into the counter.
   always_comb begin
      fire_s = '0;
      for (int i = 0; i < int'(NUM_CHECKERS); i++)
         fire_s[i] = (fire[i] === 1'b0) ? 1'b0 : 1'b1;
   end

   always_comb begin
      pc     = '0;
      lo_idx = '0;
      for (int i = int'(NUM_CHECKERS) - 1; i >= 0; i--) begin
         pc = pc + PC_W'(fire_s[i]);
         if (fire_s[i]) lo_idx = IDX_W'(i);
      end
   end

   assign fire_any   = |fire_s;
   assign fire_cycle = enable & fire_any & (state_q != ST_HALTED) & ~clear;
   assign sum        = SUM_W'(count_q) + SUM_W'(pc);
   assign cnt_sat    = (sum > SUM_W'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}} : CNT_WIDTH'(sum);
   assign halt_hit   = (MAX_FIRES != 0) && (64'(cnt_sat) >= 64'(MAX_FIRES));
   assign pop        = rec.valid & rec.ready;

   always_comb begin
      state_d = state_q;
      if (fire_cycle) begin
         case (state_q)
            ST_OK:     state_d = halt_hit ? ST_HALTED : ST_FAILED;
            ST_FAILED: if (halt_hit) state_d = ST_HALTED;
            default:   state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) state_q <= ST_OK;
      else                state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
         first_q <= '0;
         ovf_q   <= 1'b0;
      end else if (fire_cycle) begin
         count_q <= cnt_sat;
         if (state_q == ST_OK) first_q <= lo_idx;
         if (full && !pop)     ovf_q   <= 1'b1;
      end
   end

`ifdef OVL_FIRE_COLLECTOR_TS_EN
   logic [TS_WIDTH-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (reset || clear) ts_q <= '0;
      else                ts_q <= ts_q + TS_WIDTH'(1);
   end

   always_comb begin
      rec_in       = '0;
      rec_in.idx   = IDX_MAX_W'(lo_idx);
      rec_in.multi = (pc > PC_W'(1));
      rec_in.ts    = ts_q;
   end
   assign rec.ts = rec_head.ts;
`else
   always_comb begin
      rec_in       = '0;
      rec_in.idx   = IDX_MAX_W'(lo_idx);
      rec_in.multi = (pc > PC_W'(1));
   end
`endif

   ovl_fire_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (fire_cycle),
      .din   (rec_in),
      .pop   (pop),
      .dout  (rec_head),
      .full  (full),
      .empty (empty)
   );

   assign rec.valid  = ~empty;
   assign rec.idx    = IDX_W'(rec_head.idx);
   assign rec.multi  = rec_head.multi;
   assign unused_ok  = &{1'b0, rec_head};

   assign viol_count = count_q;
   assign first_idx  = first_q;
   assign status     = state_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Scoreboard bench: stimulus queues expected records, a negedge monitor pops and checks them on each handshake.
module tb_ovl_fire_collector;
   import ovl_fire_pkg::*;

   typedef struct {
      int idx;
      int multi;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, enable, clear;
   logic [7:0] fire;
   logic [15:0] viol;
   logic [2:0]  fidx;
   status_e     st;
   logic        ovf;

   logic        en2;
   logic [7:0]  fire2;
   logic [3:0]  viol2;
   logic [2:0]  fidx2;
   status_e     st2;
   logic        ovf2;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ovl_fire_collector_if #(.IDX_W(3)) rec ();
   ovl_fire_collector_if #(.IDX_W(3)) rec2 ();

   assign rec2.ready = 1'b1;

   ovl_fire_collector #(
      .NUM_CHECKERS (8), .FIFO_DEPTH (4), .CNT_WIDTH (16), .MAX_FIRES (16)
   ) dut (
      .clk (clk), .reset (reset), .enable (enable), .clear (clear), .fire (fire),
      .rec (rec), .viol_count (viol), .first_idx (fidx), .status (st), .overflow (ovf)
   );

   ovl_fire_collector #(
      .NUM_CHECKERS (8), .FIFO_DEPTH (4), .CNT_WIDTH (4), .MAX_FIRES (0)
   ) dut2 (
      .clk (clk), .reset (reset), .enable (en2), .clear (1'b0), .fire (fire2),
      .rec (rec2), .viol_count (viol2), .first_idx (fidx2), .status (st2), .overflow (ovf2)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a handshake seen here completes at the next rising edge.
   always @(negedge clk) begin
      if (!reset && rec.valid && rec.ready) begin
         if (q.size() == 0) begin
            chk("rec_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rec_idx", longint'(rec.idx), longint'(e.idx));
            chk("rec_multi", longint'(rec.multi), longint'(e.multi));
         end
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b1; clear = 1'b0; fire = '0; rec.ready = 1'b0;
      en2 = 1'b0; fire2 = '0;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_viol", viol, 0);
      chk("rst_status", int'(st), 0);
      chk("rst_first", fidx, 0);
      chk("rst_valid", rec.valid, 0);
      chk("rst_ovf", ovf, 0);

      fire = 8'h04; q.push_back('{2, 0}); tick(); fire = '0;
      chk("f04_viol", viol, 1);
      chk("f04_status", int'(st), 1);
      chk("f04_first", fidx, 2);
      chk("f04_valid", rec.valid, 1);
      chk("f04_head_idx", rec.idx, 2);
      chk("f04_head_multi", rec.multi, 0);

      fire = 8'h90; q.push_back('{4, 1}); tick();
      chk("f90_viol", viol, 3);
      chk("f90_first", fidx, 2);
      chk("f90_status", int'(st), 1);

      fire = 8'h01;
      q.push_back('{0, 0}); tick();
      q.push_back('{0, 0}); tick();
      tick();
      chk("full_viol", viol, 6);
      chk("full_ovf", ovf, 1);
      chk("stall_head_idx", rec.idx, 2);

      fire = 8'h02; rec.ready = 1'b1; q.push_back('{1, 0}); tick(); fire = '0;
      chk("pushpop_viol", viol, 7);
      chk("pushpop_ovf", ovf, 1);
      repeat (6) tick();
      chk("drain_valid", rec.valid, 0);
      chk("drain_queue", q.size(), 0);

      clear = 1'b1; fire = 8'h01; tick(); clear = 1'b0; fire = '0;
      chk("clr_viol", viol, 0);
      chk("clr_status", int'(st), 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_valid", rec.valid, 0);
      chk("clr_first", fidx, 0);

      fire = 8'hFF; q.push_back('{0, 1}); tick();
      chk("ff1_viol", viol, 8);
      chk("ff1_status", int'(st), 1);
      q.push_back('{0, 1}); tick();
      chk("ff2_viol", viol, 16);
      chk("ff2_status", int'(st), 2);
      repeat (2) tick();
      chk("halt_viol", viol, 16);
      chk("halt_status", int'(st), 2);
      fire = '0;
      repeat (3) tick();
      chk("halt_valid", rec.valid, 0);
      chk("halt_queue", q.size(), 0);

      clear = 1'b1; tick(); clear = 1'b0;
      enable = 1'b0; fire = 8'h08; tick();
      chk("dis_viol", viol, 0);
      chk("dis_status", int'(st), 0);
      chk("dis_valid", rec.valid, 0);
      enable = 1'b1; q.push_back('{3, 0}); tick(); fire = '0;
      chk("en_viol", viol, 1);
      chk("en_status", int'(st), 1);
      chk("en_first", fidx, 3);
      repeat (3) tick();
      chk("en_queue", q.size(), 0);

      en2 = 1'b1; fire2 = 8'h01;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) chk("sat_14", viol2, 14);
         if (i == 15) chk("sat_15", viol2, 15);
      end
      en2 = 1'b0; fire2 = '0;
      chk("sat_20", viol2, 15);
      chk("sat_status", int'(st2), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
